chasy_set_ctrl: RTL and testbench

CHASY_SET_CTRL -- requirements
Module: chasy_set_ctrl

---
 rtl/chasy_set_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_chasy_set_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chasy_set_ctrl.sv
// chasy_set_ctrl: push-button time-setting controller for a clock display.
// Debounces four active-low buttons (mode, inc, dec, cancel), turns them into
// prioritised one-cycle events with auto-repeat on inc/dec, and runs the
// RUN -> SET_HOUR -> SET_MIN edit sequence that loads a new time into the
// timekeeper. Define CHASY_ALARM_EN to add the alarm-setting states and the
// alarm_hour/alarm_min/alarm_on outputs.
module chasy_set_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic [0:3] button,
    input  logic       tick_1ms,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    output logic       run_en,
    output logic       set_load,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic [2:0] mode,
    output logic [5:0] blink_mask
`ifdef CHASY_ALARM_EN
    ,
    output logic [4:0] alarm_hour,
    output logic [5:0] alarm_min,
    output logic       alarm_on
`endif
);

    // Auto-repeat delays, idle timeout and blink period, all in 1 ms ticks.
    localparam logic [8:0]  REP_FIRST  = 9'd500;
    localparam logic [8:0]  REP_NEXT   = 9'd100;
    localparam logic [14:0] IDLE_LAST  = 15'd29999;
    localparam logic [8:0]  BLINK_HALF = 9'd250;
    localparam logic [8:0]  BLINK_LAST = 9'd499;

    // Encodings double as the value driven on the mode output.
    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_SET_HOUR = 3'd1,
        ST_SET_MIN  = 3'd2
`ifdef CHASY_ALARM_EN
        ,
        ST_AL_HOUR  = 3'd3,
        ST_AL_MIN   = 3'd4
`endif
    } state_t;

    state_t state_q, state_d;

    logic [0:3] btn_meta, btn_sync;
    logic [7:0] shift_q [0:3];
    logic [7:0] shift_d [0:3];
    logic [0:3] db_q, db_d;
    logic [0:3] lock_q, lock_d;
    logic [0:3] press_d;

    logic [8:0] rep_cnt_q [0:1];
    logic [8:0] rep_cnt_d [0:1];
    logic [0:1] rep_first_q, rep_first_d;
    logic [0:1] rep_d;

    logic [0:3] ev_d, ev_q;
    logic       ev_cancel, ev_mode, ev_inc, ev_dec, any_ev, timeout;

    logic [14:0] idle_q;
    logic [8:0]  blink_q;

    logic        run_en_d, set_load_d;
    logic [4:0]  set_hour_d;
    logic [5:0]  set_min_d;
`ifdef CHASY_ALARM_EN
    logic [4:0]  alarm_hour_d;
    logic [5:0]  alarm_min_d;
    logic        alarm_on_d;
`endif

    function automatic logic [4:0] hour_up(input logic [4:0] h);
        return (h >= 5'd23) ? 5'd0 : h + 5'd1;
    endfunction

    function automatic logic [4:0] hour_dn(input logic [4:0] h);
        return (h == 5'd0 || h > 5'd23) ? 5'd23 : h - 5'd1;
    endfunction

    function automatic logic [5:0] min_up(input logic [5:0] m);
        return (m >= 6'd59) ? 6'd0 : m + 6'd1;
    endfunction

    function automatic logic [5:0] min_dn(input logic [5:0] m);
        return (m == 6'd0 || m > 6'd59) ? 6'd59 : m - 6'd1;
    endfunction

    // Two-flop synchroniser for the asynchronous buttons; no reset so that it
    // already reflects the real button level when reset is released.
    always_ff @(posedge clock) begin
        btn_meta <= button;
        btn_sync <= btn_meta;
    end

    // Debounce: shift one pressed/released sample per tick, flip the level only
    // on 8 equal samples. A button stays locked (no press events) after reset
    // until it has been seen released for 8 samples.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            shift_d[i] = shift_q[i];
            db_d[i]    = db_q[i];
            lock_d[i]  = lock_q[i];
            press_d[i] = 1'b0;
            if (tick_1ms) begin
                shift_d[i] = {shift_q[i][6:0], ~btn_sync[i]};
                if (shift_d[i] == 8'hFF) begin
                    db_d[i]    = 1'b1;
                    press_d[i] = ~db_q[i] & ~lock_q[i];
                end else if (shift_d[i] == 8'h00) begin
                    db_d[i]   = 1'b0;
                    lock_d[i] = 1'b0;
                end
            end
        end
    end

    // Auto-repeat for inc (slot 0) and dec (slot 1): 500 ms to the first
    // repeat, then every 100 ms while the debounced level stays pressed.
    always_comb begin
        for (int j = 0; j < 2; j++) begin
            rep_cnt_d[j]   = rep_cnt_q[j];
            rep_first_d[j] = rep_first_q[j];
            rep_d[j]       = 1'b0;
            if (tick_1ms) begin
                if (db_q[j+1] && db_d[j+1] && !lock_q[j+1]) begin
                    rep_cnt_d[j] = rep_cnt_q[j] + 9'd1;
                    if (rep_cnt_d[j] == (rep_first_q[j] ? REP_FIRST : REP_NEXT)) begin
                        rep_d[j]       = 1'b1;
                        rep_cnt_d[j]   = '0;
                        rep_first_d[j] = 1'b0;
                    end
                end else begin
                    rep_cnt_d[j]   = '0;
                    rep_first_d[j] = 1'b1;
                end
            end
        end
    end

    assign ev_d = {press_d[0], press_d[1] | rep_d[0], press_d[2] | rep_d[1], press_d[3]};

    // Debouncer, repeat and event pulse registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                shift_q[i] <= '0;
            end
            for (int j = 0; j < 2; j++) begin
                rep_cnt_q[j] <= '0;
            end
            db_q        <= '0;
            lock_q      <= '1;
            rep_first_q <= '1;
            ev_q        <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                shift_q[i] <= shift_d[i];
            end
            for (int j = 0; j < 2; j++) begin
                rep_cnt_q[j] <= rep_cnt_d[j];
            end
            db_q        <= db_d;
            lock_q      <= lock_d;
            rep_first_q <= rep_first_d;
            ev_q        <= ev_d;
        end
    end

    // Priority resolution: cancel beats mode beats inc beats dec.
    assign ev_cancel = ev_q[3];
    assign ev_mode   = ev_q[0] & ~ev_q[3];
    assign ev_inc    = ev_q[1] & ~ev_q[0] & ~ev_q[3];
    assign ev_dec    = ev_q[2] & ~ev_q[1] & ~ev_q[0] & ~ev_q[3];
    assign any_ev    = |ev_q;
    assign timeout   = tick_1ms && (state_q != ST_RUN) && (idle_q == IDLE_LAST);

    // Next-state and edit-register logic; an idle timeout behaves like cancel.
    always_comb begin
        state_d    = state_q;
        run_en_d   = run_en;
        set_load_d = 1'b0;
        set_hour_d = set_hour;
        set_min_d  = set_min;
`ifdef CHASY_ALARM_EN
        alarm_hour_d = alarm_hour;
        alarm_min_d  = alarm_min;
        alarm_on_d   = alarm_on;
`endif
        if (ev_cancel || (timeout && !any_ev)) begin
            if (state_q != ST_RUN) begin
                state_d  = ST_RUN;
                run_en_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (ev_mode) begin
                        set_hour_d = cur_hour;
                        set_min_d  = cur_min;
                        run_en_d   = 1'b0;
                        state_d    = ST_SET_HOUR;
                    end
`ifdef CHASY_ALARM_EN
                    else if (ev_inc) begin
                        alarm_on_d = ~alarm_on;
                    end
`endif
                end
                ST_SET_HOUR: begin
                    if (ev_mode) begin
                        state_d = ST_SET_MIN;
                    end else if (ev_inc) begin
                        set_hour_d = hour_up(set_hour);
                    end else if (ev_dec) begin
                        set_hour_d = hour_dn(set_hour);
                    end
                end
                ST_SET_MIN: begin
                    if (ev_mode) begin
                        set_load_d = 1'b1;
                        run_en_d   = 1'b1;
`ifdef CHASY_ALARM_EN
                        state_d    = ST_AL_HOUR;
`else
                        state_d    = ST_RUN;
`endif
                    end else if (ev_inc) begin
                        set_min_d = min_up(set_min);
                    end else if (ev_dec) begin
                        set_min_d = min_dn(set_min);
                    end
                end
`ifdef CHASY_ALARM_EN
                ST_AL_HOUR: begin
                    if (ev_mode) begin
                        state_d = ST_AL_MIN;
                    end else if (ev_inc) begin
                        alarm_hour_d = hour_up(alarm_hour);
                    end else if (ev_dec) begin
                        alarm_hour_d = hour_dn(alarm_hour);
                    end
                end
                ST_AL_MIN: begin
                    if (ev_mode) begin
                        state_d = ST_RUN;
                    end else if (ev_inc) begin
                        alarm_min_d = min_up(alarm_min);
                    end else if (ev_dec) begin
                        alarm_min_d = min_dn(alarm_min);
                    end
                end
`endif
                default: begin
                    state_d  = ST_RUN;
                    run_en_d = 1'b1;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_RUN;
            run_en   <= 1'b1;
            set_load <= 1'b0;
            set_hour <= '0;
            set_min  <= '0;
`ifdef CHASY_ALARM_EN
            alarm_hour <= '0;
            alarm_min  <= '0;
            alarm_on   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            run_en   <= run_en_d;
            set_load <= set_load_d;
            set_hour <= set_hour_d;
            set_min  <= set_min_d;
`ifdef CHASY_ALARM_EN
            alarm_hour <= alarm_hour_d;
            alarm_min  <= alarm_min_d;
            alarm_on   <= alarm_on_d;
`endif
        end
    end

    // Idle and blink-phase counters both restart on any event or state change.
    always_ff @(posedge clock) begin
        if (reset || any_ev || (state_d != state_q)) begin
            idle_q  <= '0;
            blink_q <= '0;
        end else if (tick_1ms) begin
            if (state_q != ST_RUN) begin
                idle_q <= idle_q + 15'd1;
            end
            blink_q <= (blink_q == BLINK_LAST) ? 9'd0 : blink_q + 9'd1;
        end
    end

    // Blank the field being edited during the second half of each blink period.
    always_comb begin
        blink_mask = '0;
        if (blink_q >= BLINK_HALF) begin
            case (state_q)
                ST_SET_HOUR: blink_mask = 6'b110000;
                ST_SET_MIN:  blink_mask = 6'b001100;
`ifdef CHASY_ALARM_EN
                ST_AL_HOUR:  blink_mask = 6'b110000;
                ST_AL_MIN:   blink_mask = 6'b001100;
`endif
                default:     blink_mask = '0;
            endcase
        end
    end

    assign mode = state_q;

endmodule

// File: tb/tb_chasy_set_ctrl.sv
// tb_chasy_set_ctrl: scoreboard bench for chasy_set_ctrl. Directed button
// sequences push the expected output snapshots; a monitor compares every
// observed change of the DUT outputs against the head of the queue.
module tb_chasy_set_ctrl;

    localparam logic [0:3] B_MODE = 4'b1000;
    localparam logic [0:3] B_INC  = 4'b0100;
    localparam logic [0:3] B_DEC  = 4'b0010;
    localparam logic [0:3] B_CAN  = 4'b0001;

    localparam logic [2:0] M_RUN = 3'd0;
    localparam logic [2:0] M_SH  = 3'd1;
    localparam logic [2:0] M_SM  = 3'd2;
    localparam logic [2:0] M_AH  = 3'd3;
    localparam logic [2:0] M_AM  = 3'd4;

    logic       clock = 1'b0;
    logic       reset;
    logic [0:3] button;
    logic       tick_1ms;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic       run_en, set_load;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic [2:0] mode;
    logic [5:0] blink_mask;
`ifdef CHASY_ALARM_EN
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic       alarm_on;
`endif

    typedef struct packed {
        logic [2:0] md;
        logic [4:0] hr;
        logic [5:0] mn;
        logic       ld;
        logic       run;
        logic [4:0] ahr;
        logic [5:0] amn;
        logic       aon;
    } snap_t;

    snap_t      expQ [$];
    int         checks = 0;
    int         fails = 0;
    bit         monitorOn = 1'b0;
    logic [4:0] expAlHour = '0;
    logic [5:0] expAlMin = '0;
    logic       expAlOn = 1'b0;

    chasy_set_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .button     (button),
        .tick_1ms   (tick_1ms),
        .cur_hour   (cur_hour),
        .cur_min    (cur_min),
        .run_en     (run_en),
        .set_load   (set_load),
        .set_hour   (set_hour),
        .set_min    (set_min),
        .mode       (mode),
        .blink_mask (blink_mask)
`ifdef CHASY_ALARM_EN
        ,
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .alarm_on   (alarm_on)
`endif
    );

    // 100 MHz clock.
    always #5 clock = ~clock;

    // Accelerated 1 ms strobe: high for one cycle out of every two.
    initial begin
        tick_1ms = 1'b0;
        forever begin
            @(posedge clock);
            #1 tick_1ms = 1'b1;
            @(posedge clock);
            #1 tick_1ms = 1'b0;
        end
    end

    function automatic snap_t sampleDut();
        snap_t s;
        s.md  = mode;
        s.hr  = set_hour;
        s.mn  = set_min;
        s.ld  = set_load;
        s.run = run_en;
`ifdef CHASY_ALARM_EN
        s.ahr = alarm_hour;
        s.amn = alarm_min;
        s.aon = alarm_on;
`else
        s.ahr = '0;
        s.amn = '0;
        s.aon = 1'b0;
`endif
        return s;
    endfunction

    function automatic string fmtSnap(input snap_t s);
        return $sformatf("mode=%0d set=%0d:%0d load=%0b run=%0b alarm=%0d:%0d on=%0b",
                         s.md, s.hr, s.mn, s.ld, s.run, s.ahr, s.amn, s.aon);
    endfunction

    // Monitor: every change of the observable outputs is one transaction.
    initial begin
        snap_t prev, now, want;
        prev = '0;
        forever begin
            @(negedge clock);
            now = sampleDut();
            if (monitorOn && (now !== prev)) begin
                checks++;
                if (expQ.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL unexpected output: got %s, required no change", fmtSnap(now));
                end else begin
                    want = expQ.pop_front();
                    if (now !== want) begin
                        fails++;
                        $display("[TB] FAIL output change: got %s, required %s", fmtSnap(now), fmtSnap(want));
                    end
                end
            end
            prev = now;
        end
    end

    task automatic pushExp(input logic [2:0] m, input logic [4:0] h, input logic [5:0] mi,
                           input logic ld, input logic run);
        snap_t s;
        s.md  = m;
        s.hr  = h;
        s.mn  = mi;
        s.ld  = ld;
        s.run = run;
        s.ahr = expAlHour;
        s.amn = expAlMin;
        s.aon = expAlOn;
        expQ.push_back(s);
    endtask

    task automatic waitTicks(input int n);
        repeat (2 * n) @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    // Press (and later release) the buttons in mask, leaving others as they are.
    task automatic applyStimulus(input logic [0:3] mask, input int holdTicks);
        button = button & ~mask;
        waitTicks(holdTicks);
        button = button | mask;
        waitTicks(11);
    endtask

    task automatic waitDrain(input string name, input int budgetTicks);
        int t;
        t = 0;
        while (expQ.size() != 0 && t < 2 * budgetTicks) begin
            @(posedge clock);
            t++;
        end
        #1;
        checks++;
        if (expQ.size() != 0) begin
            fails++;
            $display("[TB] FAIL %s: %0d expected outputs still pending, required 0", name, expQ.size());
            expQ.delete();
        end
    endtask

    task automatic commitTime(input logic [4:0] h, input logic [5:0] m);
`ifdef CHASY_ALARM_EN
        pushExp(M_AH, h, m, 1'b1, 1'b1);
        pushExp(M_AH, h, m, 1'b0, 1'b1);
        applyStimulus(B_MODE, 12);
        pushExp(M_RUN, h, m, 1'b0, 1'b1);
        applyStimulus(B_CAN, 12);
`else
        pushExp(M_RUN, h, m, 1'b1, 1'b1);
        pushExp(M_RUN, h, m, 1'b0, 1'b1);
        applyStimulus(B_MODE, 12);
`endif
    endtask

    initial begin
        button   = '1;
        reset    = 1'b1;
        cur_hour = 5'd23;
        cur_min  = 6'd59;
        repeat (4) @(posedge clock);
        @(negedge clock);
        checkOutput("reset mode", int'(mode), 0);
        checkOutput("reset run_en", int'(run_en), 1);
        checkOutput("reset set_load", int'(set_load), 0);
        checkOutput("reset set_hour", int'(set_hour), 0);
        checkOutput("reset set_min", int'(set_min), 0);
        checkOutput("reset blink_mask", int'(blink_mask), 0);
`ifdef CHASY_ALARM_EN
        checkOutput("reset alarm_hour", int'(alarm_hour), 0);
        checkOutput("reset alarm_min", int'(alarm_min), 0);
        checkOutput("reset alarm_on", int'(alarm_on), 0);
`endif
        @(posedge clock);
        #1 reset = 1'b0;
        monitorOn = 1'b1;
        waitTicks(12);

        // A 3 ms glitch on mode must not produce an event.
        button[0] = 1'b0;
        waitTicks(3);
        button[0] = 1'b1;
        waitTicks(20);
        checkOutput("glitch mode", int'(mode), 0);
`ifndef CHASY_ALARM_EN
        applyStimulus(B_INC, 12);
        applyStimulus(B_DEC, 12);
        checkOutput("run inc/dec ignored", int'(mode), 0);
`endif

        // 23:59 -> 00:58 with hour wrap on inc and blink phase checks.
        pushExp(M_SH, 5'd23, 6'd59, 1'b0, 1'b0);
        applyStimulus(B_MODE, 12);
        waitDrain("enter set hour", 20);
        checkOutput("blink visible on entry", int'(blink_mask), 0);
        waitTicks(287);
        checkOutput("hour blanked", int'(blink_mask), 'b110000);
        waitTicks(250);
        checkOutput("hour visible again", int'(blink_mask), 0);
        pushExp(M_SH, 5'd0, 6'd59, 1'b0, 1'b0);
        applyStimulus(B_INC, 12);
        pushExp(M_SM, 5'd0, 6'd59, 1'b0, 1'b0);
        applyStimulus(B_MODE, 12);
        waitTicks(287);
        checkOutput("minute blanked", int'(blink_mask), 'b001100);
        pushExp(M_SM, 5'd0, 6'd58, 1'b0, 1'b0);
        applyStimulus(B_DEC, 12);
        checkOutput("blink restart on event", int'(blink_mask), 0);
        commitTime(5'd0, 6'd58);
        waitDrain("commit 00:58", 20);
        waitTicks(300);
        checkOutput("run blink_mask", int'(blink_mask), 0);

        // Remaining wrap cases: hour dec 0->23, minute inc 59->0, dec 0->59.
        cur_hour = 5'd0;
        cur_min  = 6'd59;
        pushExp(M_SH, 5'd0, 6'd59, 1'b0, 1'b0);
        applyStimulus(B_MODE, 12);
        pushExp(M_SH, 5'd23, 6'd59, 1'b0, 1'b0);
        applyStimulus(B_DEC, 12);
        pushExp(M_SM, 5'd23, 6'd59, 1'b0, 1'b0);
        applyStimulus(B_MODE, 12);
        pushExp(M_SM, 5'd23, 6'd0, 1'b0, 1'b0);
        applyStimulus(B_INC, 12);
        pushExp(M_SM, 5'd23, 6'd59, 1'b0, 1'b0);
        applyStimulus(B_DEC, 12);
        pushExp(M_RUN, 5'd23, 6'd59, 1'b0, 1'b1);
        applyStimulus(B_CAN, 12);
        waitDrain("wrap sequence", 20);

        // Auto-repeat: press plus six repeats inside a 1050 ms hold.
        cur_hour = 5'd3;
        cur_min  = 6'd10;
        pushExp(M_SH, 5'd3, 6'd10, 1'b0, 1'b0);
        applyStimulus(B_MODE, 12);
        pushExp(M_SM, 5'd3, 6'd10, 1'b0, 1'b0);
        applyStimulus(B_MODE, 12);
        for (int k = 11; k <= 17; k++) begin
            pushExp(M_SM, 5'd3, 6'(k), 1'b0, 1'b0);
        end
        applyStimulus(B_INC, 1050);
        waitDrain("auto repeat", 20);
        checkOutput("repeat set_min", int'(set_min), 17);
        pushExp(M_RUN, 5'd3, 6'd17, 1'b0, 1'b1);
        applyStimulus(B_CAN, 12);
        waitDrain("cancel from set min", 20);

        // Cancel beats mode in the same cycle; then the 30 s idle timeout.
        cur_hour = 5'd12;
        cur_min  = 6'd34;
        pushExp(M_SH, 5'd12, 6'd34, 1'b0, 1'b0);
        applyStimulus(B_MODE, 12);
        pushExp(M_RUN, 5'd12, 6'd34, 1'b0, 1'b1);
        applyStimulus(B_MODE | B_CAN, 12);
        waitDrain("mode+cancel", 20);
        pushExp(M_SH, 5'd12, 6'd34, 1'b0, 1'b0);
        applyStimulus(B_MODE, 12);
        waitDrain("enter set hour again", 20);
        pushExp(M_RUN, 5'd12, 6'd34, 1'b0, 1'b1);
        waitTicks(29900);
        checkOutput("no early timeout", int'(mode), 1);
        waitDrain("idle timeout", 300);

        // Reset mid-edit with inc held: no event until released and re-pressed.
        cur_hour = 5'd5;
        cur_min  = 6'd20;
        pushExp(M_SH, 5'd5, 6'd20, 1'b0, 1'b0);
        applyStimulus(B_MODE, 12);
        pushExp(M_SM, 5'd5, 6'd20, 1'b0, 1'b0);
        applyStimulus(B_MODE, 12);
        pushExp(M_SM, 5'd5, 6'd21, 1'b0, 1'b0);
        button[1] = 1'b0;
        waitDrain("held inc first event", 40);
        pushExp(M_RUN, 5'd0, 6'd0, 1'b0, 1'b1);
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        waitDrain("reset mid edit", 5);
        waitTicks(20);
        checkOutput("after reset mode", int'(mode), 0);
        checkOutput("after reset set_hour", int'(set_hour), 0);
        pushExp(M_SH, 5'd5, 6'd20, 1'b0, 1'b0);
        applyStimulus(B_MODE, 12);
        waitDrain("enter set hour with inc held", 20);
        waitTicks(600);
        checkOutput("held inc locked out", int'(set_hour), 5);
        button[1] = 1'b1;
        waitTicks(15);
        pushExp(M_SH, 5'd6, 6'd20, 1'b0, 1'b0);
        applyStimulus(B_INC, 12);
        pushExp(M_RUN, 5'd6, 6'd20, 1'b0, 1'b1);
        applyStimulus(B_CAN, 12);
        waitDrain("inc after re-press", 20);

`ifdef CHASY_ALARM_EN
        // Commit 08:00, set alarm 07:30, then toggle alarm_on from RUN.
        cur_hour = 5'd8;
        cur_min  = 6'd0;
        pushExp(M_SH, 5'd8, 6'd0, 1'b0, 1'b0);
        applyStimulus(B_MODE, 12);
        pushExp(M_SM, 5'd8, 6'd0, 1'b0, 1'b0);
        applyStimulus(B_MODE, 12);
        pushExp(M_AH, 5'd8, 6'd0, 1'b1, 1'b1);
        pushExp(M_AH, 5'd8, 6'd0, 1'b0, 1'b1);
        applyStimulus(B_MODE, 12);
        for (int k = 1; k <= 7; k++) begin
            expAlHour = 5'(k);
            pushExp(M_AH, 5'd8, 6'd0, 1'b0, 1'b1);
            applyStimulus(B_INC, 12);
        end
        pushExp(M_AM, 5'd8, 6'd0, 1'b0, 1'b1);
        applyStimulus(B_MODE, 12);
        for (int k = 1; k <= 30; k++) begin
            expAlMin = 6'(k);
            pushExp(M_AM, 5'd8, 6'd0, 1'b0, 1'b1);
        end
        applyStimulus(B_INC, 3350);
        pushExp(M_RUN, 5'd8, 6'd0, 1'b0, 1'b1);
        applyStimulus(B_MODE, 12);
        waitDrain("alarm set", 20);
        checkOutput("alarm_hour", int'(alarm_hour), 7);
        checkOutput("alarm_min", int'(alarm_min), 30);
        expAlOn = 1'b1;
        pushExp(M_RUN, 5'd8, 6'd0, 1'b0, 1'b1);
        applyStimulus(B_INC, 12);
        waitDrain("alarm toggle", 20);
        checkOutput("alarm_on", int'(alarm_on), 1);
`endif

        waitDrain("final drain", 20);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
